// File: rtl/vec_pkg.sv
// Shared types for the vector execute unit: opcodes, sequencer states, latched instruction.
package vec_pkg;

  localparam int NVREG_DEF  = 4;
  localparam int VLEN_DEF   = 32;
  localparam int NLANES_DEF = 16;
  localparam int SEW_DEF    = 32;

  typedef enum logic [2:0] {
    VOP_ADD = 3'd0,
    VOP_SUB = 3'd1,
    VOP_MUL = 3'd2,
    VOP_AND = 3'd3,
    VOP_OR  = 3'd4,
    VOP_XOR = 3'd5,
    VOP_SLL = 3'd6,
    VOP_MAX = 3'd7
  } vop_e;

  // Encodings double as the externally visible phase trace value.
  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_EXEC  = 2'd1,
    SEQ_DRAIN = 2'd2
  } seq_state_e;

  typedef struct packed {
    vop_e                               op;
    logic [$clog2(NVREG_DEF)-1:0]       vd;
    logic [$clog2(NVREG_DEF)-1:0]       vs1;
    logic [$clog2(NVREG_DEF)-1:0]       vs2;
    logic [$clog2(VLEN_DEF+1)-1:0]      vl;
  } vec_inst_t;

endpackage

// File: rtl/vec_lane_alu.sv
// One SEW-bit lane of the element-wise vector ALU; purely combinational.
module vec_lane_alu
  import vec_pkg::*;
#(
  parameter int SEW = SEW_DEF
) (
  input  vop_e           op_i,
  input  logic [SEW-1:0] a_i,
  input  logic [SEW-1:0] b_i,
  output logic [SEW-1:0] y_o
);

  localparam int SHW = $clog2(SEW);

  always_comb begin
    y_o = '0;
    case (op_i)
      VOP_ADD: y_o = a_i + b_i;
      VOP_SUB: y_o = a_i - b_i;
      VOP_MUL: y_o = a_i * b_i;
      VOP_AND: y_o = a_i & b_i;
      VOP_OR:  y_o = a_i | b_i;
      VOP_XOR: y_o = a_i ^ b_i;
      // Only the low log2(SEW) bits of the shift amount are significant.
      VOP_SLL: y_o = a_i << b_i[SHW-1:0];
      VOP_MAX: y_o = ($signed(a_i) > $signed(b_i)) ? a_i : b_i;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/vec_strip_sequencer.sv
// Vector execute unit: register file, strip-mining sequencer and an NLANES-wide
// read/execute/write pipeline with a host element load/read port.
module vec_strip_sequencer
  import vec_pkg::*;
#(
  parameter int NVREG  = NVREG_DEF,
  parameter int VLEN   = VLEN_DEF,
  parameter int NLANES = NLANES_DEF,
  parameter int SEW    = SEW_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inst_valid,
  output logic                       inst_ready,
  input  logic [2:0]                 inst_op,
  input  logic [$clog2(NVREG)-1:0]   inst_vd,
  input  logic [$clog2(NVREG)-1:0]   inst_vs1,
  input  logic [$clog2(NVREG)-1:0]   inst_vs2,
  input  logic [$clog2(VLEN+1)-1:0]  inst_vl,
  output logic                       done,
  output logic [1:0]                 phase,
  input  logic                       wr_en,
  input  logic [$clog2(NVREG)-1:0]   wr_vreg,
  input  logic [$clog2(VLEN)-1:0]    wr_elem,
  input  logic [SEW-1:0]             wr_data,
  output logic                       wr_reject,
  input  logic [$clog2(NVREG)-1:0]   rd_vreg,
  input  logic [$clog2(VLEN)-1:0]    rd_elem,
  output logic [SEW-1:0]             rd_data
);

  localparam int VAW  = $clog2(NVREG);
  localparam int VEW  = $clog2(VLEN);
  localparam int VLW  = $clog2(VLEN+1);
  localparam int MAXB = (VLEN + NLANES - 1) / NLANES;
  localparam int BW   = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam int EIW0 = $clog2(MAXB * NLANES) + 1;
  localparam int EIW  = (EIW0 > VLW) ? EIW0 : VLW;

  localparam logic [VLW-1:0] VLEN_L   = VLW'(VLEN);
  localparam logic [EIW-1:0] VLEN_E   = EIW'(VLEN);
  localparam logic [EIW-1:0] NLANES_E = EIW'(NLANES);

  logic [SEW-1:0] vrf [0:NVREG-1][0:VLEN-1];

  seq_state_e     state_q, state_d;
  logic           done_q, done_d;
  logic           wrReject_q;
  logic [SEW-1:0] rdData_q;
  logic [BW-1:0]  beat_q;
  vec_inst_t      inst_q;

  logic           stageValid_q;
  logic [NLANES-1:0] stageMask_q;
  logic [BW-1:0]  stageBeat_q;
  logic [VAW-1:0] stageVd_q;
  logic [SEW-1:0] stageA_q [NLANES];
  logic [SEW-1:0] stageB_q [NLANES];

  logic           accept;
  logic [VLW-1:0] vlClamp;
  logic [EIW-1:0] beatBase;
  logic           lastBeat;
  logic [EIW-1:0] rdElemIdx [NLANES];
  logic [SEW-1:0] rdA [NLANES];
  logic [SEW-1:0] rdB [NLANES];
  logic [NLANES-1:0] rdMask;
  logic [EIW-1:0] wbElemIdx [NLANES];
  logic [SEW-1:0] laneRes [NLANES];

  // Per-index range tables, so address checks never compare against a constant.
  logic [(1<<VAW)-1:0] vregOk;
  logic [(1<<VEW)-1:0] elemOk;

  for (genvar g = 0; g < (1 << VAW); g++) begin : g_vregOk
    assign vregOk[g] = (g < NVREG);
  end
  for (genvar g = 0; g < (1 << VEW); g++) begin : g_elemOk
    assign elemOk[g] = (g < VLEN);
  end

  assign accept     = inst_valid && (state_q == SEQ_IDLE);
  assign vlClamp    = (inst_vl > VLEN_L) ? VLEN_L : inst_vl;
  assign beatBase   = EIW'(beat_q) * NLANES_E;
  assign lastBeat   = (beatBase + NLANES_E) >= EIW'(inst_q.vl);

  assign inst_ready = (state_q == SEQ_IDLE);
  assign phase      = state_q;
  assign done       = done_q;
  assign wr_reject  = wrReject_q;
  assign rd_data    = rdData_q;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (accept) begin
          if (vlClamp == '0) done_d = 1'b1;
          else               state_d = SEQ_EXEC;
        end
      end
      SEQ_EXEC: begin
        if (lastBeat) state_d = SEQ_DRAIN;
      end
      SEQ_DRAIN: begin
        state_d = SEQ_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SEQ_IDLE;
      done_q     <= 1'b0;
      wrReject_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      wrReject_q <= wr_en && (state_q != SEQ_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                       beat_q <= '0;
    else if (accept)               beat_q <= '0;
    else if (state_q == SEQ_EXEC)  beat_q <= beat_q + BW'(1);
  end

  // The latched instruction is only consulted outside IDLE, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      inst_q.op  <= vop_e'(inst_op);
      inst_q.vd  <= inst_vd;
      inst_q.vs1 <= inst_vs1;
      inst_q.vs2 <= inst_vs2;
      inst_q.vl  <= vlClamp;
    end
  end

  always_comb begin
    rdMask = '0;
    for (int l = 0; l < NLANES; l++) begin
      rdElemIdx[l] = beatBase + EIW'(l);
      rdMask[l]    = rdElemIdx[l] < EIW'(inst_q.vl);
      rdA[l]       = '0;
      rdB[l]       = '0;
      if (rdElemIdx[l] < VLEN_E) begin
        if (vregOk[inst_q.vs1]) rdA[l] = vrf[inst_q.vs1][rdElemIdx[l][VEW-1:0]];
        if (vregOk[inst_q.vs2]) rdB[l] = vrf[inst_q.vs2][rdElemIdx[l][VEW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stageValid_q <= 1'b0;
      stageMask_q  <= '0;
      stageBeat_q  <= '0;
      stageVd_q    <= '0;
      for (int l = 0; l < NLANES; l++) begin
        stageA_q[l] <= '0;
        stageB_q[l] <= '0;
      end
    end else begin
      stageValid_q <= (state_q == SEQ_EXEC);
      if (state_q == SEQ_EXEC) begin
        stageMask_q <= rdMask;
        stageBeat_q <= beat_q;
        stageVd_q   <= inst_q.vd;
        for (int l = 0; l < NLANES; l++) begin
          stageA_q[l] <= rdA[l];
          stageB_q[l] <= rdB[l];
        end
      end
    end
  end

  for (genvar l = 0; l < NLANES; l++) begin : g_lane
    vec_lane_alu #(.SEW(SEW)) u_alu (
      .op_i (inst_q.op),
      .a_i  (stageA_q[l]),
      .b_i  (stageB_q[l]),
      .y_o  (laneRes[l])
    );
    assign wbElemIdx[l] = EIW'(stageBeat_q) * NLANES_E + EIW'(l);
  end

  // Host writes only land in IDLE and pipeline writes only while busy, so the
  // two never collide; a reset edge still lets an in-flight beat retire.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == SEQ_IDLE) && vregOk[wr_vreg] && elemOk[wr_elem])
      vrf[wr_vreg][wr_elem] <= wr_data;
    if (stageValid_q && vregOk[stageVd_q]) begin
      for (int l = 0; l < NLANES; l++) begin
        if (stageMask_q[l]) vrf[stageVd_q][wbElemIdx[l][VEW-1:0]] <= laneRes[l];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      rdData_q <= '0;
    else if (vregOk[rd_vreg] && elemOk[rd_elem])
      rdData_q <= vrf[rd_vreg][rd_elem];
    else
      rdData_q <= '0;
  end

endmodule
